// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline <-> hazard controller signal bundle               |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
interface hazard_ctrl_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [2:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        ex_halt;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        halted;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_jump, ex_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, halted,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_jump, ex_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, halted,
           stall_cycles, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl : load-use stall, branch/jump flush and halt-drain sequencing   |
// |               Optional statistics counters enabled by HAZARD_STATS_EN.      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 2
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [1:0] LS_CNT_INIT = 2'(LOAD_STALL_CYCLES - 2);
  localparam logic [1:0] DR_CNT_INIT = 2'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ex_valid_q, ex_valid_d;
  logic       lu, rd, hl;
  logic       pc_en, ifid_en, ifid_flush, idex_en, halted;

  // A bubbled ID/EX register still holds stale control bits; ex_valid masks them.
  assign lu = ex_valid_q & hz.ex_mem_read & (hz.ex_rt != 3'd0) &
              ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
  assign rd = ex_valid_q & (hz.ex_branch_taken | hz.ex_jump);
  assign hl = ex_valid_q & hz.ex_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 2'd0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    halted     = 1'b0;
    case (state_q)
      RUN: begin
        if (hl) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_en    = 1'b0;
          cnt_d      = DR_CNT_INIT;
          state_d    = (DRAIN_CYCLES == 1) ? HALTED : DRAIN;
        end else if (rd) begin
          ifid_flush = 1'b1;
          idex_en    = 1'b0;
        end else if (lu) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_d   = LS_CNT_INIT;
            state_d = LSTALL;
          end
        end
      end
      LSTALL, DRAIN: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        if (cnt_q == 2'd0) begin
          state_d = (state_q == LSTALL) ? RUN : HALTED;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HALTED: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        halted  = 1'b1;
      end
      default: state_d = RUN;
    endcase
    ex_valid_d = idex_en & ~ifid_flush;
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_en    = idex_en;
  assign hz.halted     = halted;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  logic        stall_inc, flush_inc;

  assign stall_inc = (state_q == LSTALL) | ((state_q == RUN) & lu & ~rd & ~hl);
  assign flush_inc = (state_q == RUN) & rd & ~hl;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (flush_inc && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = 16'h0000;
  assign hz.flush_count  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl : two hazard_ctrl configurations against a behavioural model |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] t_rs, t_rt, t_ert;
  logic       t_uses, t_mr, t_br, t_j, t_h;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  assign ifa.id_rs = t_rs;   assign ifb.id_rs = t_rs;
  assign ifa.id_rt = t_rt;   assign ifb.id_rt = t_rt;
  assign ifa.id_uses_rt = t_uses;      assign ifb.id_uses_rt = t_uses;
  assign ifa.ex_mem_read = t_mr;       assign ifb.ex_mem_read = t_mr;
  assign ifa.ex_rt = t_ert;            assign ifb.ex_rt = t_ert;
  assign ifa.ex_branch_taken = t_br;   assign ifb.ex_branch_taken = t_br;
  assign ifa.ex_jump = t_j;            assign ifb.ex_jump = t_j;
  assign ifa.ex_halt = t_h;            assign ifb.ex_halt = t_h;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .hz(ifa.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .hz(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remaining stopped cycles per DUT rather than explicit states.
  int    lsc [2] = '{1, 3};
  int    drc [2] = '{2, 1};
  bit    m_exv [2];
  int    m_stall_left [2];
  int    m_drain_left [2];
  bit    m_halted [2];
  int    m_stalls [2];
  int    m_flushes [2];
  logic [15:0] got [7];
  logic [15:0] exp_v [7];
  string sig_name [7] = '{"pc_en", "ifid_en", "ifid_flush", "idex_en",
                          "halted", "stall_cycles", "flush_count"};

  task automatic chk(input string name, input int k, input logic [15:0] g, input logic [15:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, k, g, e, $time);
    end
  endtask

  task automatic get_outputs(input int k);
    if (k == 0) begin
      got[0] = 16'(ifa.pc_en);  got[1] = 16'(ifa.ifid_en); got[2] = 16'(ifa.ifid_flush);
      got[3] = 16'(ifa.idex_en); got[4] = 16'(ifa.halted);
      got[5] = ifa.stall_cycles; got[6] = ifa.flush_count;
    end else begin
      got[0] = 16'(ifb.pc_en);  got[1] = 16'(ifb.ifid_en); got[2] = 16'(ifb.ifid_flush);
      got[3] = 16'(ifb.idex_en); got[4] = 16'(ifb.halted);
      got[5] = ifb.stall_cycles; got[6] = ifb.flush_count;
    end
  endtask

  task automatic model_step(input int k);
    bit lu, rd, hl;
    bit pc, ie, fl, xe, hz;
    if (!rst_n) begin
      m_exv[k] = 0; m_stall_left[k] = 0; m_drain_left[k] = 0;
      m_halted[k] = 0; m_stalls[k] = 0; m_flushes[k] = 0;
    end
    exp_v[5] = STATS ? 16'(m_stalls[k])  : 16'h0;
    exp_v[6] = STATS ? 16'(m_flushes[k]) : 16'h0;
    pc = 1; ie = 1; fl = 0; xe = 1; hz = 0;
    if (!rst_n) begin
      // outputs of the reset state; no update
    end else if (m_halted[k]) begin
      pc = 0; ie = 0; xe = 0; hz = 1;
    end else if (m_drain_left[k] > 0) begin
      pc = 0; ie = 0; xe = 0;
      m_drain_left[k]--;
      if (m_drain_left[k] == 0) m_halted[k] = 1;
    end else if (m_stall_left[k] > 0) begin
      pc = 0; ie = 0; xe = 0;
      m_stall_left[k]--;
      if (m_stalls[k] < 65535) m_stalls[k]++;
    end else begin
      lu = m_exv[k] && t_mr && (t_ert != 0) && ((t_ert == t_rs) || (t_uses && (t_ert == t_rt)));
      rd = m_exv[k] && (t_br || t_j);
      hl = m_exv[k] && t_h;
      if (hl) begin
        pc = 0; fl = 1; xe = 0;
        if (drc[k] == 1) m_halted[k] = 1;
        else m_drain_left[k] = drc[k];
      end else if (rd) begin
        fl = 1; xe = 0;
        if (m_flushes[k] < 65535) m_flushes[k]++;
      end else if (lu) begin
        pc = 0; ie = 0; xe = 0;
        if (m_stalls[k] < 65535) m_stalls[k]++;
        m_stall_left[k] = lsc[k] - 1;
      end
    end
    if (rst_n) m_exv[k] = xe && !fl;
    exp_v[0] = 16'(pc); exp_v[1] = 16'(ie); exp_v[2] = 16'(fl);
    exp_v[3] = 16'(xe); exp_v[4] = 16'(hz);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      get_outputs(k);
      model_step(k);
      for (int i = 0; i < 7; i++) chk(sig_name[i], k, got[i], exp_v[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] rs, input logic [2:0] rt, input logic uses,
                        input logic mr, input logic [2:0] ert, input logic br,
                        input logic j, input logic h);
    t_rs = rs; t_rt = rt; t_uses = uses; t_mr = mr; t_ert = ert;
    t_br = br; t_j = j; t_h = h;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    // reset state
    @(negedge clk);
    chk("rst_pc_en", 0, 16'(ifa.pc_en), 16'h1);
    chk("rst_idex_en", 0, 16'(ifa.idex_en), 16'h1);
    chk("rst_flush", 0, 16'(ifa.ifid_flush), 16'h0);
    chk("rst_stall", 0, ifa.stall_cycles, 16'h0);
    // load-use on r3
    step(); set_in(3, 0, 0, 1, 3, 0, 0, 0);
    @(negedge clk);
    chk("lu_pc_en", 0, 16'(ifa.pc_en), 16'h0);
    chk("lu_ifid_en", 0, 16'(ifa.ifid_en), 16'h0);
    chk("lu_idex_en", 0, 16'(ifa.idex_en), 16'h0);
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu1_resume", 0, 16'(ifa.pc_en), 16'h1);
    chk("lu1_count", 0, ifa.stall_cycles, STATS ? 16'd1 : 16'd0);
    chk("lu3_stall2", 1, 16'(ifb.pc_en), 16'h0);
    step();
    @(negedge clk);
    chk("lu3_stall3", 1, 16'(ifb.pc_en), 16'h0);
    // r0 never creates a hazard
    step(); set_in(0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu3_resume", 1, 16'(ifb.pc_en), 16'h1);
    chk("lu3_count", 1, ifb.stall_cycles, STATS ? 16'd3 : 16'd0);
    chk("r0_no_stall", 0, 16'(ifa.idex_en), 16'h1);
    // branch beats load-use, held branch bit not re-acted on
    step(); set_in(3, 0, 0, 1, 3, 1, 0, 0);
    @(negedge clk);
    chk("br_flush", 0, 16'(ifa.ifid_flush), 16'h1);
    chk("br_pc_en", 0, 16'(ifa.pc_en), 16'h1);
    chk("br_idex_en", 0, 16'(ifa.idex_en), 16'h0);
    step();
    @(negedge clk);
    chk("br_no_refl", 0, 16'(ifa.ifid_flush), 16'h0);
    chk("br_count", 0, ifa.flush_count, STATS ? 16'd1 : 16'd0);
    chk("br_no_stall", 0, ifa.stall_cycles, STATS ? 16'd1 : 16'd0);
    // halt drain
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("hl_flush", 0, 16'(ifa.ifid_flush), 16'h1);
    chk("hl_pc_en", 0, 16'(ifa.pc_en), 16'h0);
    step(); set_in(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("drain1_halted", 0, 16'(ifa.halted), 16'h0);
    chk("d1_halted", 1, 16'(ifb.halted), 16'h1);
    step();
    @(negedge clk);
    chk("drain2_halted", 0, 16'(ifa.halted), 16'h0);
    step();
    @(negedge clk);
    chk("halted", 0, 16'(ifa.halted), 16'h1);
    chk("halted_flush", 0, 16'(ifa.ifid_flush), 16'h0);
    step();
    @(negedge clk);
    chk("halted_pc_en", 0, 16'(ifa.pc_en), 16'h0);
    step(); rst_n = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_async_pc", 0, 16'(ifa.pc_en), 16'h1);
    chk("rst_async_halt", 0, 16'(ifa.halted), 16'h0);
    step(); rst_n = 1'b1;
    // reset in the middle of a 3-cycle stall
    step(); set_in(5, 0, 0, 1, 5, 0, 0, 0);
    step(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("lstall_rst_pc", 1, 16'(ifb.pc_en), 16'h1);
    chk("lstall_rst_ie", 1, 16'(ifb.ifid_en), 16'h1);
    chk("lstall_rst_cnt", 1, ifb.stall_cycles, 16'h0);
    step(); rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ((ifa.halted && ifb.halted) || ($urandom_range(0, 299) == 0)) rst_n = 1'b0;
      t_ert  = 3'($urandom_range(0, 7));
      t_rs   = ($urandom_range(0, 2) == 0) ? t_ert : 3'($urandom_range(0, 7));
      t_rt   = ($urandom_range(0, 2) == 0) ? t_ert : 3'($urandom_range(0, 7));
      t_uses = 1'($urandom_range(0, 1));
      t_mr   = 1'($urandom_range(0, 1));
      t_br   = ($urandom_range(0, 9) == 0);
      t_j    = ($urandom_range(0, 19) == 0);
      t_h    = ($urandom_range(0, 39) == 0);
    end

    // back-to-back load-use hazards
    step(); rst_n = 1'b0; set_in(3, 0, 0, 1, 3, 0, 0, 0);
    step(); rst_n = 1'b1;
`ifdef HAZARD_STATS_EN
    for (int c = 0; c < 90000 && ifb.stall_cycles != 16'hFFFF; c++) step();
    repeat (20) step();
    chk("stall_sat", 1, ifb.stall_cycles, 16'hFFFF);
`else
    repeat (2000) step();
    chk("stall_tied0_a", 0, ifa.stall_cycles, 16'h0);
    chk("stall_tied0_b", 1, ifb.stall_cycles, 16'h0);
`endif
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
